// File: rtl/spc_stack_ctl.sv
// Stack controller over a 32xWIDTH strobe-latched RAM: push, pop and exchange.
// Optional SPC_OVF_TRAP_EN: reject overflow/underflow and set sticky err.
module spc_stack_ctl #(
    parameter int WIDTH = 19,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    output logic             ack,
    output logic [WIDTH-1:0] rdata,
    output logic [AW-1:0]    ptr,
    output logic             empty,
    output logic             full,
    output logic             err,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             ram_ce,
    output logic             ram_we_n,
    output logic             ram_strobe
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, STB, CAP} state_t;

    typedef struct packed {
        logic             xchg;
        logic [WIDTH-1:0] data;
    } op_t;

    state_t      state;
    op_t         op;
    logic [AW:0] count;
    logic [AW:0] cnt_inc, cnt_dec, cnt_xchg;
    logic        reject;

    always_comb begin
        cnt_inc  = (count == CNT_MAX) ? count : count + 1'b1;
        cnt_dec  = (count == '0) ? count : count - 1'b1;
        cnt_xchg = (count == '0) ? (AW+1)'(1) : count;
    end

`ifdef SPC_OVF_TRAP_EN
    // an exchange on an empty stack counts as a rejected pop
    assign reject = (push && !pop && full) || (pop && empty);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op         <= '0;
            ptr        <= '1;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            err        <= 1'b0;
            ack        <= 1'b0;
            ready      <= 1'b1;
            rdata      <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_ce     <= 1'b0;
            ram_we_n   <= 1'b1;
            ram_strobe <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (push || pop) begin
                        if (reject) begin
`ifdef SPC_OVF_TRAP_EN
                            err <= 1'b1;
`endif
                            ack <= 1'b1;
                        end else if (push && !pop) begin
                            state    <= WR;
                            ready    <= 1'b0;
                            op       <= '{xchg: 1'b0, data: wdata};
                            ram_addr <= ptr + 1'b1;
                            ram_din  <= wdata;
                            ram_we_n <= 1'b0;
                            ram_ce   <= 1'b1;
                        end else begin
                            state      <= STB;
                            ready      <= 1'b0;
                            op         <= '{xchg: push, data: wdata};
                            ram_addr   <= ptr;
                            ram_strobe <= 1'b1;
                            ram_ce     <= 1'b1;
                        end
                    end
                end
                STB: begin
                    ram_strobe <= 1'b0;
                    state      <= CAP;
                end
                CAP: begin
                    // RAM latched its output on the strobe fall; take it now
                    rdata <= ram_dout;
                    if (op.xchg) begin
                        state    <= WR;
                        ram_din  <= op.data;
                        ram_we_n <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        ready  <= 1'b1;
                        ack    <= 1'b1;
                        ram_ce <= 1'b0;
                        ptr    <= ptr - 1'b1;
                        count  <= cnt_dec;
                        empty  <= (cnt_dec == '0);
                        full   <= (cnt_dec == CNT_MAX);
                    end
                end
                WR: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    ack      <= 1'b1;
                    ram_we_n <= 1'b1;
                    ram_ce   <= 1'b0;
                    if (op.xchg) begin
                        count <= cnt_xchg;
                        empty <= (cnt_xchg == '0);
                        full  <= (cnt_xchg == CNT_MAX);
                    end else begin
                        ptr   <= ptr + 1'b1;
                        count <= cnt_inc;
                        empty <= (cnt_inc == '0);
                        full  <= (cnt_inc == CNT_MAX);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spc_stack_ctl.sv
// Scoreboard bench for spc_stack_ctl: directed ops queue expected acks, a monitor checks them.
module tb_spc_stack_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0, pop = 1'b0;
    logic [18:0] wdata = '0;
    logic        ready, ack, empty, full, err;
    logic [18:0] rdata, ram_din;
    logic [18:0] ram_dout = '0;
    logic [4:0]  ptr, ram_addr;
    logic        ram_ce, ram_we_n, ram_strobe;

    spc_stack_ctl dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .wdata(wdata),
        .ready(ready), .ack(ack), .rdata(rdata), .ptr(ptr),
        .empty(empty), .full(full), .err(err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ce(ram_ce), .ram_we_n(ram_we_n), .ram_strobe(ram_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [18:0] rd;
        logic [4:0]  ptr;
        logic        emp, ful, er;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0, strobe_cnt = 0, ce_cnt = 0;
    logic [4:0]  wr_addr;
    logic [18:0] wr_data;
    logic [18:0] mem [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write on WR cycles, read while strobe is high
    always @(negedge clk) begin
        if (ram_ce) ce_cnt++;
        if (ram_strobe) begin
            strobe_cnt++;
            ram_dout = mem[ram_addr];
        end
        if (ram_ce && !ram_we_n) begin
            wr_cnt++;
            wr_addr = ram_addr;
            wr_data = ram_din;
            mem[ram_addr] = ram_din;
        end
    end

    always @(negedge clk) begin
        if (!reset && ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {31'd0, ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_rdata"}, {13'd0, rdata}, {13'd0, mon_e.rd});
                check({mon_e.name, "_ptr"}, {27'd0, ptr}, {27'd0, mon_e.ptr});
                check({mon_e.name, "_empty"}, {31'd0, empty}, {31'd0, mon_e.emp});
                check({mon_e.name, "_full"}, {31'd0, full}, {31'd0, mon_e.ful});
                check({mon_e.name, "_err"}, {31'd0, err}, {31'd0, mon_e.er});
                check({mon_e.name, "_ready_with_ack"}, {31'd0, ready}, 32'd1);
                check({mon_e.name, "_ack_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    task automatic op(input string name, input logic p, input logic q, input logic [18:0] d,
                      input logic [18:0] erd, input logic [4:0] eptr,
                      input logic eemp, input logic eful, input logic eerr, input int lat);
        exp_t e;
        int t;
        t = 0;
        while (!ready && t < 20) begin @(negedge clk); t++; end
        check({name, "_ready"}, {31'd0, ready}, 32'd1);
        wr_cnt = 0; strobe_cnt = 0; ce_cnt = 0;
        e.name = name; e.rd = erd; e.ptr = eptr;
        e.emp = eemp; e.ful = eful; e.er = eerr; e.cyc = cyc + lat;
        exp_q.push_back(e);
        push = p; pop = q; wdata = d;
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
        if (exp_q.size() != 0) begin
            check({name, "_ack_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input logic full_check);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        if (full_check) begin
            check("rst_ptr", {27'd0, ptr}, 32'd31);
            check("rst_empty", {31'd0, empty}, 32'd1);
            check("rst_full", {31'd0, full}, 32'd0);
            check("rst_err", {31'd0, err}, 32'd0);
            check("rst_ack", {31'd0, ack}, 32'd0);
            check("rst_rdata", {13'd0, rdata}, 32'd0);
            check("rst_we_n", {31'd0, ram_we_n}, 32'd1);
            check("rst_strobe", {31'd0, ram_strobe}, 32'd0);
            check("rst_ce", {31'd0, ram_ce}, 32'd0);
            check("rst_addr", {27'd0, ram_addr}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", {31'd0, ready}, 32'd1);
        exp_q.delete();
    endtask

    initial begin
        int t;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        do_reset(1'b1);

        // single push lands at address 0
        op("push0", 1, 0, 19'h12345, 19'h0, 5'd0, 0, 0, 0, 2);
        check("push0_wr_cnt", wr_cnt, 1);
        check("push0_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("push0_wr_data", {13'd0, wr_data}, 32'h12345);

        // LIFO order
        do_reset(1'b0);
        op("p1", 1, 0, 19'h1, 19'h0, 5'd0, 0, 0, 0, 2);
        op("p2", 1, 0, 19'h2, 19'h0, 5'd1, 0, 0, 0, 2);
        op("p3", 1, 0, 19'h3, 19'h0, 5'd2, 0, 0, 0, 2);
        op("pop3", 0, 1, 19'h0, 19'h3, 5'd1, 0, 0, 0, 3);
        check("pop3_strobe_cnt", strobe_cnt, 1);
        op("pop2", 0, 1, 19'h0, 19'h2, 5'd0, 0, 0, 0, 3);
        check("pop2_strobe_cnt", strobe_cnt, 1);
        op("pop1", 0, 1, 19'h0, 19'h1, 5'd31, 1, 0, 0, 3);
        check("pop1_strobe_cnt", strobe_cnt, 1);

        // exchange returns old top and leaves ptr alone
        do_reset(1'b0);
        op("p7", 1, 0, 19'h7, 19'h0, 5'd0, 0, 0, 0, 2);
        op("xchg", 1, 1, 19'h9, 19'h7, 5'd0, 0, 0, 0, 4);
        check("xchg_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("xchg_wr_data", {13'd0, wr_data}, 32'h9);
        check("xchg_strobe_cnt", strobe_cnt, 1);
        op("pop9", 0, 1, 19'h0, 19'h9, 5'd31, 1, 0, 0, 3);

        // fill to full
        do_reset(1'b0);
        for (int i = 0; i < 32; i++)
            op("fill", 1, 0, 19'h100 + 19'(i), 19'h0, 5'(i), 0, (i == 31), 0, 2);

        // reset during STB of a pop aborts it
        push = 1'b0; pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        t = 0;
        while (!ram_strobe && t < 10) begin @(negedge clk); t++; end
        check("abort_saw_strobe", {31'd0, ram_strobe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_strobe_low", {31'd0, ram_strobe}, 32'd0);
        check("abort_no_ack", {31'd0, ack}, 32'd0);
        check("abort_ptr", {27'd0, ptr}, 32'd31);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_empty", {31'd0, empty}, 32'd1);
        check("abort_ram_kept", {13'd0, mem[31]}, 32'h11F);

        // refill, then overflow push
        for (int i = 0; i < 32; i++)
            op("refill", 1, 0, 19'h200 + 19'(i), 19'h0, 5'(i), 0, (i == 31), 0, 2);
`ifdef SPC_OVF_TRAP_EN
        op("ovf", 1, 0, 19'h3AB, 19'h0, 5'd31, 0, 1, 1, 1);
        check("ovf_wr_cnt", wr_cnt, 0);
        check("ovf_ce_cnt", ce_cnt, 0);
        check("ovf_ram0", {13'd0, mem[0]}, 32'h200);
`else
        op("ovf", 1, 0, 19'h3AB, 19'h0, 5'd0, 0, 1, 0, 2);
        check("ovf_wr_cnt", wr_cnt, 1);
        check("ovf_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("ovf_ram0", {13'd0, mem[0]}, 32'h3AB);
`endif

        // underflow: pop and exchange on an empty stack
        do_reset(1'b0);
`ifdef SPC_OVF_TRAP_EN
        op("unf_pop", 0, 1, 19'h0, 19'h0, 5'd31, 1, 0, 1, 1);
        check("unf_pop_ce_cnt", ce_cnt, 0);
        do_reset(1'b0);
        op("unf_xchg", 1, 1, 19'h55, 19'h0, 5'd31, 1, 0, 1, 1);
        check("unf_xchg_ce_cnt", ce_cnt, 0);
`else
        op("unf_pop", 0, 1, 19'h0, 19'h21F, 5'd30, 1, 0, 0, 3);
        do_reset(1'b0);
        op("unf_xchg", 1, 1, 19'h55, 19'h21F, 5'd31, 0, 0, 0, 4);
        check("unf_xchg_wr_addr", {27'd0, wr_addr}, 32'd31);
        op("unf_pop55", 0, 1, 19'h0, 19'h55, 5'd30, 1, 0, 0, 3);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spc_stack_ctl.md
SPC_STACK_CTL -- requirements
Module: spc_stack_ctl

Interface
REQ-001 Parameter WIDTH, default 19, stack word width in bits.
REQ-002 Parameter AW, default 5, RAM address width; depth is 2**AW (32).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-004 push  in  1  push request, sampled only when ready=1.
REQ-005 pop  in  1  pop request, sampled only when ready=1.
REQ-006 wdata  in  WIDTH  word to push, sampled with push.
REQ-007 ready  out  1  high only in IDLE.
REQ-008 ack  out  1  one-cycle pulse when an operation completes.
REQ-009 rdata  out  WIDTH  popped word, held from ack until the next pop ack.
REQ-010 ptr  out  AW  index of the top-of-stack entry.
REQ-011 empty, full  out  1 each  stack occupancy flags.
REQ-012 err  out  1  sticky overflow/underflow flag (macro-dependent).
REQ-013 ram_addr  out  AW; ram_din  out  WIDTH; ram_dout  in  WIDTH; ram_ce, ram_we_n (drives both slice write enables), ram_strobe  out  1 each. These drive the 32xWIDTH write-while-read RAM array, which latches read data on the falling edge of its strobe.

Function
REQ-014 The FSM SHALL have states IDLE, WR, STB and CAP; all outputs SHALL be registered.
REQ-015 Push only: sampled in cycle N; WR in N+1 with ram_addr=ptr+1 mod 32, ram_din=wdata, ram_we_n=0, ram_ce=1; ptr updates and ack=1 in N+2.
REQ-016 Pop only: STB in N+1 with ram_addr=ptr, ram_strobe=1, ram_ce=1; CAP in N+2 with ram_strobe=0, and ram_dout is captured at the end of N+2; rdata valid, ack=1 and ptr=ptr-1 mod 32 in N+3.
REQ-017 Push and pop together (exchange): STB, then CAP, then WR, all at the current ptr; the old top is returned on rdata; ptr and count are unchanged; ack=1 in N+4.
REQ-018 ram_we_n SHALL be 1 in every state except WR; ram_strobe SHALL be 1 only in STB; ram_ce SHALL be 0 in IDLE.
REQ-019 A 6-bit count SHALL track occupancy: empty is count==0, full is count==32.
REQ-020 ack SHALL be exactly one cycle long, and ready SHALL be 1 in the same cycle.
REQ-021 Requests arriving while ready=0 SHALL be ignored and are not queued.
REQ-022 Exchange on an empty stack SHALL follow the underflow rules in REQ-027/REQ-028, with count becoming 1.

Reset
REQ-023 Reset SHALL force IDLE, ptr=31, count=0, empty=1, full=0, err=0, ack=0, rdata=0, ram_we_n=1, ram_strobe=0, ram_ce=0, ram_addr=0, and ready=1 in the cycle after reset deasserts.
REQ-024 Reset asserted mid-operation SHALL abort the operation: no ack, no ptr change, and a write not yet issued SHALL NOT be performed.
REQ-025 Reset SHALL NOT clear RAM contents.

Configuration
REQ-026 Macro SPC_OVF_TRAP_EN defined: a push when full, or a pop when empty, SHALL be rejected. The block SHALL return to IDLE with ack=1 one cycle later, with no RAM access, no ptr or count change, and err set; only reset clears err.
REQ-027 SPC_OVF_TRAP_EN undefined: ptr SHALL wrap modulo 32 and the access SHALL proceed. count SHALL saturate at 0 and 32, and err SHALL be tied to 0.
REQ-028 An exchange on an empty stack SHALL be a rejected pop when the macro is defined; otherwise it SHALL proceed, with rdata taken from RAM[31].

Verification
REQ-029 Reset, then push 0x12345 -> ram_we_n=0 one cycle at ram_addr=0; ack at N+2; ptr=0, empty=0.
REQ-030 Push 0x1, 0x2, 0x3, then pop x3 -> rdata 0x3, 0x2, 0x1; each ack at N+3; ram_strobe high one cycle per pop; empty=1 at the end.
REQ-031 Push 32 words -> full=1, ptr=31; 33rd push gives err=1 and RAM unchanged with the macro, or a write at addr 0 without it.
REQ-032 With 0x7 on top, push+pop with wdata=0x9 -> rdata=0x7, ack at N+4, then pop -> rdata=0x9, ptr unchanged by the exchange.
REQ-033 Reset asserted in STB of a pop -> no ack, ptr unchanged, ram_strobe=0 the next cycle, ready=1 after release.
REQ-034 Pop on empty with the macro defined -> ack at N+1, err=1, no ram_ce activity.
